cop_perfcnt: RTL
================

Name: cop_perfcnt

Overview:
Performance-counter coprocessor that sits on the coprocessor side of the CPU coprocessor interface. It counts the CNT* event pulses the interface produces, plus a free-running cycle count. Counters and control registers are reached through the CRD*/CWR* general and control register ports. The block returns read data on CRDDATA and raises overflow through the active-low CONDINN condition line back to the CPU.

Parameters:
CNTW, 32, counter width in bits; legal range 1..32; reads are zero-extended to 32 bits, writes take CWRDATA[CNTW-1:0].

Ports:
SYSCLK  in  1  system clock; all state updates on its rising edge.
RESET  in  1  asynchronous, active-high reset.
CRDADDR  in  5  read register number.
CRDGEN  in  1  read general register CRDADDR.
CRDCON  in  1  read control register CRDADDR.
CRDDATA  out  32  read data.
CWRADDR  in  5  write register number.
CWRGEN  in  1  write general register CWRADDR.
CWRCON  in  1  write control register CWRADDR.
CWRDATA  in  32  write data.
CNTINST, CNTIMISS, CNTISTALL, CNTDMISS, CNTDSTALL, CNTDLOAD, CNTDSTORE  in  1 each  single-cycle event pulses, at most one count per cycle each.
CONDINN  out  1  active-low condition: 0 when any enabled overflow is pending.

Behaviour:
- Register map, general space:
  - GEN0: cycle counter, increments every cycle.
  - GEN1..GEN7: CNTINST, CNTIMISS, CNTISTALL, CNTDMISS, CNTDSTALL, CNTDLOAD, CNTDSTORE counters, in that order.
  - GEN8..31: read 0, writes ignored.
- Register map, control space:
  - CON0: bits[7:0] per-counter enable EN, bit 8 FRZ (freeze on overflow); other bits read 0.
  - CON1: bits[7:0] overflow status OVF, write-1-to-clear.
  - CON2: bits[7:0] overflow condition enable OIE.
  - CON3..31: read 0, writes ignored.
- Reset: all counters, EN, FRZ, OVF and OIE clear to 0. CONDINN=1. CRDDATA=0 while no read strobe is active.
- Counter i increments by 1 in a cycle when all of the following hold:
  - EN[i]=1;
  - its event is 1 (always 1 for GEN0);
  - no freeze is active. Freeze = FRZ & (|OVF).
- Wrap: counter at 2^CNTW-1 plus an increment goes to 0 and sets OVF[i] in the same edge.
- Write vs increment in the same cycle: the CWRGEN write to GEN i wins. No increment occurs and no OVF is set for i from that cycle.
- OVF W1C vs new overflow in the same cycle: the set wins, so the bit stays 1.
- CWRGEN and CWRCON asserted together: both writes are performed in their respective spaces.
- Read is combinational from current register state, i.e. the value before this cycle's edge; zero latency.
  - CRDGEN has priority over CRDCON.
  - Neither strobe asserted: CRDDATA=0.
- A write followed by a read of the same register in the next cycle returns the written value.
- Reading is side-effect free; OVF is cleared only by W1C.
- CONDINN = ~|(OVF & OIE). It is a decode of registered state and glitch-free relative to SYSCLK.
- RESET asserted mid-count clears everything asynchronously. The first increment occurs at the first rising edge after deassertion, and only if EN has been written.
- Event pulses arriving while EN[i]=0 or frozen are dropped; they are not queued.

Test Plan:
- Reset then read: RESET pulse, then CRDCON=1 with CRDADDR=0 -> CRDDATA=0x00000000, CONDINN=1. CRDGEN with CRDADDR=5 -> 0.
- Enable and count: CWRCON CON0=0x000000FF, then 10 CNTDLOAD pulses -> GEN6 reads 10. GEN0 reads exactly the number of cycles elapsed since the enable write's edge.
- Overflow and condition: CNTW=32, write GEN1=0xFFFFFFFE, CON2=0x02, EN[1]=1, then 2 CNTINST pulses -> GEN1=0, CON1 reads 0x02, CONDINN=0. Write CON1=0x02 -> OVF cleared, CONDINN=1 next cycle.
- Collisions:
  - Write GEN3=0x100 in the same cycle as a CNTISTALL pulse -> GEN3=0x100.
  - W1C of OVF[1] in the same cycle GEN1 wraps -> CON1 still reads 0x02.
- Freeze: FRZ=1 with EN=0xFF; GEN0 overflows (preload 0xFFFFFFFF) -> every counter holds its value on subsequent events until OVF is cleared, then resumes.
- CNTW=8 build: write 0x1234 to GEN2 -> reads 0x34. 256 CNTIMISS pulses from 0 -> GEN2=0, OVF[2]=1.

Source files
------------

// File: rtl/cop_perfcnt.sv
// Performance-counter coprocessor: a free-running cycle counter plus seven
// event counters, with per-counter enable, freeze-on-overflow, sticky
// overflow status and an active-low overflow condition line to the CPU.
module cop_perfcnt #(
   parameter int CNTW = 32
) (
   input  logic        SYSCLK,
   input  logic        RESET,
   input  logic [4:0]  CRDADDR,
   input  logic        CRDGEN,
   input  logic        CRDCON,
   output logic [31:0] CRDDATA,
   input  logic [4:0]  CWRADDR,
   input  logic        CWRGEN,
   input  logic        CWRCON,
   input  logic [31:0] CWRDATA,
   input  logic        CNTINST,
   input  logic        CNTIMISS,
   input  logic        CNTISTALL,
   input  logic        CNTDMISS,
   input  logic        CNTDSTALL,
   input  logic        CNTDLOAD,
   input  logic        CNTDSTORE,
   output logic        CONDINN
);

   // Counter storage: index 0 is the cycle counter, 1..7 follow the event order.
   logic [CNTW-1:0] cnt [8];
   logic [7:0]      en;
   logic            frz;
   logic [7:0]      ovf;
   logic [7:0]      oie;

   logic [7:0]      evt;
   logic [7:0]      wr_hit;
   logic [7:0]      inc;
   logic [7:0]      wrap;
   logic [7:0]      ovf_clr;
   logic            freeze;

   // Per-counter increment/wrap decode; a general write to a counter suppresses
   // that counter's increment (and therefore its overflow) in the same cycle.
   always_comb begin
      evt     = {CNTDSTORE, CNTDLOAD, CNTDSTALL, CNTDMISS,
                 CNTISTALL, CNTIMISS, CNTINST, 1'b1};
      freeze  = frz & (|ovf);
      wr_hit  = '0;
      inc     = '0;
      wrap    = '0;
      for (int i = 0; i < 8; i++) begin
         wr_hit[i] = CWRGEN && (CWRADDR == 5'(i));
         inc[i]    = en[i] & evt[i] & ~freeze & ~wr_hit[i];
         wrap[i]   = inc[i] && (cnt[i] == {CNTW{1'b1}});
      end
      ovf_clr = (CWRCON && (CWRADDR == 5'd1)) ? CWRDATA[7:0] : 8'h00;
   end

   // Counter update: write has priority over increment; increment wraps to 0.
   always_ff @(posedge SYSCLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wr_hit[i]) begin
               cnt[i] <= CWRDATA[CNTW-1:0];
            end else if (inc[i]) begin
               cnt[i] <= cnt[i] + CNTW'(1);
            end
         end
      end
   end

   // Control registers: enable/freeze and condition-enable are plain writes;
   // overflow status is write-1-to-clear with a new overflow taking precedence.
   always_ff @(posedge SYSCLK or posedge RESET) begin
      if (RESET) begin
         en  <= '0;
         frz <= 1'b0;
         ovf <= '0;
         oie <= '0;
      end else begin
         if (CWRCON && (CWRADDR == 5'd0)) begin
            en  <= CWRDATA[7:0];
            frz <= CWRDATA[8];
         end
         if (CWRCON && (CWRADDR == 5'd2)) begin
            oie <= CWRDATA[7:0];
         end
         ovf <= (ovf & ~ovf_clr) | wrap;
      end
   end

   // Zero-latency read mux; general space wins when both strobes are set.
   always_comb begin
      CRDDATA = '0;
      if (CRDGEN) begin
         if (CRDADDR[4:3] == 2'b00) begin
            CRDDATA[CNTW-1:0] = cnt[CRDADDR[2:0]];
         end
      end else if (CRDCON) begin
         case (CRDADDR)
            5'd0:    CRDDATA[8:0] = {frz, en};
            5'd1:    CRDDATA[7:0] = ovf;
            5'd2:    CRDDATA[7:0] = oie;
            default: CRDDATA      = '0;
         endcase
      end
   end

   // Condition line is a pure decode of registered state, so it only moves
   // just after a clock edge.
   assign CONDINN = ~|(ovf & oie);

endmodule
